// File: rtl/shift_register_universal_param.sv
// Parametrised universal shift register with a multi-step shift sequencer.
// A start in IDLE latches mode/amount; shift and rotate modes then step autonomously until done.
module shift_register_universal_param #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sin,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [AMT_W-1:0] shift_amt,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_LOAD   = 3'b001;
    localparam logic [2:0] MODE_SHR    = 3'b010;
    localparam logic [2:0] MODE_SHL    = 3'b011;
    localparam logic [2:0] MODE_ROR    = 3'b100;
    localparam logic [2:0] MODE_ROL    = 3'b101;
    localparam logic [2:0] MODE_STICKY = 3'b110;
    localparam logic [2:0] MODE_CLEAR  = 3'b111;

    localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic [2:0]       mode_r;
    logic [2:0]       mode_nxt_s;
    logic [AMT_W-1:0] cnt_r;
    logic [AMT_W-1:0] cnt_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic             sout_s;

    // One step of the selected operation applied to the current contents.
    function automatic logic [WIDTH-1:0] step_value(
        input logic [WIDTH-1:0] cur,
        input logic [2:0]       op,
        input logic             ser,
        input logic [WIDTH-1:0] par
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            MODE_HOLD:   res = cur;
            MODE_LOAD:   res = par;
            MODE_SHR:    res = {ser, cur[WIDTH-1:1]};
            MODE_SHL:    res = {cur[WIDTH-2:0], ser};
            MODE_ROR:    res = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:    res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_STICKY: res = {ser | cur[WIDTH-1], cur[WIDTH-1:1]};
            MODE_CLEAR:  res = {WIDTH{1'b0}};
            default:     res = cur;
        endcase
        return res;
    endfunction

    // Hold, load and clear complete on the accepting edge; everything else is sequenced.
    function automatic logic is_single_cycle(input logic [2:0] op);
        logic res;
        case (op)
            MODE_HOLD, MODE_LOAD, MODE_CLEAR: res = 1'b1;
            default:                          res = 1'b0;
        endcase
        return res;
    endfunction

    // Next-state, next-contents and latched-control logic of the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        q_nxt_s     = q_r;
        mode_nxt_s  = mode_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mode_nxt_s = mode;
                    if (is_single_cycle(mode)) begin
                        q_nxt_s     = step_value(q_r, mode, sin, load_val);
                        state_nxt_s = ST_DONE;
                    end else if (shift_amt == {AMT_W{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        cnt_nxt_s   = shift_amt;
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                q_nxt_s   = step_value(q_r, mode_r, sin, load_val);
                cnt_nxt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, contents and status flags; status is decoded from the next state so it is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            mode_r  <= MODE_HOLD;
            cnt_r   <= {AMT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            q_r     <= q_nxt_s;
            mode_r  <= mode_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Serial output: the bit that the latched mode would push out next.
    always_comb begin
        sout_s = q_r[0];
        case (mode_r)
            MODE_SHL, MODE_ROL: sout_s = q_r[WIDTH-1];
            default:            sout_s = q_r[0];
        endcase
    end

    assign q    = q_r;
    assign sout = sout_s;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_shift_register_universal_param.sv
// Bench for shift_register_universal_param: schedule-based reference model checked every cycle,
// plus directed scenarios with hand-computed values and a randomized run.
module tb_shift_register_universal_param;

    localparam int W     = 8;
    localparam int AMT_W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] load_val;
    logic         sin;
    logic [2:0]   mode;
    logic         start;
    logic [AMT_W-1:0] shift_amt;
    logic [W-1:0] q;
    logic         sout;
    logic         busy;
    logic         done;

    int checks;
    int errors;

    shift_register_universal_param #(.WIDTH(W), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_val  (load_val),
        .sin       (sin),
        .mode      (mode),
        .start     (start),
        .shift_amt (shift_amt),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference operation written as plain arithmetic on the register value.
    function automatic logic [W-1:0] model_op(input logic [W-1:0] v, input logic [2:0] m,
                                              input logic s, input logic [W-1:0] ld);
        logic [W-1:0] sv;
        logic [W-1:0] fill;
        sv   = W'(s);
        fill = W'(s | v[W-1]);
        case (m)
            3'd0:    return v;
            3'd1:    return ld;
            3'd2:    return (v >> 1) | (sv << (W-1));
            3'd3:    return (v << 1) | sv;
            3'd4:    return (v >> 1) | (v << (W-1));
            3'd5:    return (v << 1) | (v >> (W-1));
            3'd6:    return (v >> 1) | (fill << (W-1));
            default: return '0;
        endcase
    endfunction

    // Model: on an accepted start the whole per-cycle schedule is planned as a queue.
    typedef struct packed {
        logic step;
        logic busy;
        logic done;
    } item_t;

    item_t        sched[$];
    item_t        cur_item;
    logic [W-1:0] m_q;
    logic [2:0]   m_mode;
    logic         e_busy;
    logic         e_done;
    logic         e_sout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched.delete();
            m_q    = '0;
            m_mode = 3'd0;
            e_busy = 1'b0;
            e_done = 1'b0;
        end else if (sched.size() > 0) begin
            cur_item = sched.pop_front();
            if (cur_item.step) m_q = model_op(m_q, m_mode, sin, load_val);
            e_busy = cur_item.busy;
            e_done = cur_item.done;
        end else if (start) begin
            m_mode = mode;
            if (mode == 3'd0 || mode == 3'd1 || mode == 3'd7) begin
                m_q    = model_op(m_q, mode, sin, load_val);
                e_busy = 1'b0;
                e_done = 1'b1;
                sched.push_back(item_t'{step: 1'b0, busy: 1'b0, done: 1'b0});
            end else if (shift_amt == '0) begin
                e_busy = 1'b0;
                e_done = 1'b1;
                sched.push_back(item_t'{step: 1'b0, busy: 1'b0, done: 1'b0});
            end else begin
                e_busy = 1'b1;
                e_done = 1'b0;
                for (int k = 1; k <= int'(shift_amt); k++)
                    sched.push_back(item_t'{step: 1'b1, busy: (k < int'(shift_amt)),
                                            done: (k == int'(shift_amt))});
                sched.push_back(item_t'{step: 1'b0, busy: 1'b0, done: 1'b0});
            end
        end else begin
            e_busy = 1'b0;
            e_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            e_sout = (m_mode == 3'd3 || m_mode == 3'd5) ? m_q[W-1] : m_q[0];
            chk("cyc_q", 32'(q), 32'(m_q));
            chk("cyc_busy", 32'(busy), 32'(e_busy));
            chk("cyc_done", 32'(done), 32'(e_done));
            chk("cyc_sout", 32'(sout), 32'(e_sout));
        end
    end

    logic [W-1:0] hist_q[0:39];
    logic         hist_sout[0:39];
    logic         hist_busy[0:39];
    logic         hist_done[0:39];
    int           hlen;
    logic [W-1:0] post_q;
    logic         post_busy;
    logic         post_done;

    // Issue one operation from IDLE (at a falling edge); record outputs until done, then one more cycle.
    task automatic run_op(input logic [2:0] m, input int amt, input logic [W-1:0] ld,
                          input logic s, input int pulse_at, input bit rnd);
        bit seen;
        mode      = m;
        shift_amt = AMT_W'(amt);
        load_val  = ld;
        sin       = s;
        start     = 1'b1;
        hlen      = 0;
        seen      = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            hist_q[i]    = q;
            hist_sout[i] = sout;
            hist_busy[i] = busy;
            hist_done[i] = done;
            hlen         = i + 1;
            seen         = done;
            if (i == pulse_at) begin
                start     = 1'b1;
                mode      = 3'b111;
                shift_amt = AMT_W'($urandom_range(1, 15));
                load_val  = W'($urandom);
            end else begin
                start = 1'b0;
                if (rnd) begin
                    mode      = 3'($urandom);
                    shift_amt = AMT_W'($urandom);
                    load_val  = W'($urandom);
                end
            end
            if (rnd) sin = 1'($urandom);
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start     = 1'b0;
        post_q    = q;
        post_busy = busy;
        post_done = done;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int amt;
        int pa;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 3'd0;
        shift_amt = '0;
        load_val  = '0;
        sin       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load, start a shift, then reset asynchronously mid-run.
        run_op(3'b001, 0, 8'hA5, 1'b0, -1, 1'b0);
        mode = 3'b011; shift_amt = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_busy_before", 32'(busy), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_q", 32'(q), 32'h0);
        chk("t1_async_busy", 32'(busy), 32'h0);
        chk("t1_async_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Parallel load.
        run_op(3'b001, 0, 8'hA5, 1'b0, -1, 1'b0);
        chk("t2_q", 32'(hist_q[0]), 32'hA5);
        chk("t2_done", 32'(hist_done[0]), 32'h1);
        chk("t2_busy", 32'(hist_busy[0]), 32'h0);
        chk("t2_done_after", 32'(post_done), 32'h0);

        // Shift right by 3 with sin=1.
        run_op(3'b010, 3, 8'h00, 1'b1, -1, 1'b0);
        chk("t3_len", 32'(hlen), 32'd4);
        chk("t3_q1", 32'(hist_q[1]), 32'hD2);
        chk("t3_q2", 32'(hist_q[2]), 32'hE9);
        chk("t3_q3", 32'(hist_q[3]), 32'hF4);
        chk("t3_sout0", 32'(hist_sout[0]), 32'h1);
        chk("t3_sout1", 32'(hist_sout[1]), 32'h0);
        chk("t3_sout2", 32'(hist_sout[2]), 32'h1);
        chk("t3_busy", 32'({hist_busy[0], hist_busy[1], hist_busy[2], hist_busy[3]}), 32'b1110);

        // Rotates.
        run_op(3'b001, 0, 8'h3C, 1'b0, -1, 1'b0);
        run_op(3'b101, 8, 8'h00, 1'b1, -1, 1'b0);
        chk("t4_rol8", 32'(hist_q[8]), 32'h3C);
        run_op(3'b101, 1, 8'h00, 1'b1, -1, 1'b0);
        chk("t4_rol1", 32'(hist_q[1]), 32'h78);
        run_op(3'b100, 9, 8'h00, 1'b0, -1, 1'b0);
        chk("t4_ror9", 32'(hist_q[9]), 32'h3C);

        // Sticky right.
        run_op(3'b001, 0, 8'h81, 1'b0, -1, 1'b0);
        run_op(3'b110, 2, 8'h00, 1'b0, -1, 1'b0);
        chk("t5_q1", 32'(hist_q[1]), 32'hC0);
        chk("t5_q2", 32'(hist_q[2]), 32'hE0);
        run_op(3'b001, 0, 8'h01, 1'b0, -1, 1'b0);
        run_op(3'b110, 1, 8'h00, 1'b0, -1, 1'b0);
        chk("t5_q3", 32'(hist_q[1]), 32'h00);

        // Zero-length shift.
        run_op(3'b001, 0, 8'h5A, 1'b0, -1, 1'b0);
        run_op(3'b010, 0, 8'h00, 1'b1, -1, 1'b0);
        chk("t6_amt0_q", 32'(hist_q[0]), 32'h5A);
        chk("t6_amt0_done", 32'(hist_done[0]), 32'h1);
        chk("t6_amt0_busy", 32'(hist_busy[0]), 32'h0);

        // Start pulsed during RUN is ignored.
        run_op(3'b010, 4, 8'h00, 1'b0, 1, 1'b0);
        chk("t6_run_len", 32'(hlen), 32'd5);
        chk("t6_run_q", 32'(hist_q[4]), 32'h05);

        // Start in the done cycle is ignored.
        run_op(3'b001, 0, 8'h5A, 1'b0, -1, 1'b0);
        run_op(3'b011, 2, 8'h00, 1'b1, 2, 1'b0);
        chk("t6_done_q", 32'(post_q), 32'h6B);
        chk("t6_done_busy", 32'(post_busy), 32'h0);
        chk("t6_done_done", 32'(post_done), 32'h0);

        // Randomized operations, inputs scrambled while busy, occasional stray starts.
        for (int n = 0; n < 150; n++) begin
            amt = int'($urandom_range(0, 15));
            pa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, amt + 1)) : -1;
            run_op(3'($urandom), amt, W'($urandom), 1'($urandom), pa, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                mode      = 3'($urandom);
                shift_amt = AMT_W'($urandom);
                load_val  = W'($urandom);
                sin       = 1'($urandom);
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
